// File: rtl/contrast_change_logger.sv
// Logs PWM on-time changes with a free-running tick timestamp into a
// first-word-fall-through FIFO drained over a valid/ready read port.
module contrast_change_logger #(
   parameter int PWM_REG_WIDTH       = 10,
   parameter int TS_WIDTH            = 16,
   parameter int TICK_CYCLES         = 16000,
   parameter int FIFO_ADDR_WIDTH     = 3,
   parameter int SUPPRESS_DUPLICATES = 1,
   parameter int DROP_CNT_WIDTH      = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       value_changed,
   input  logic [PWM_REG_WIDTH-1:0]   value,
   input  logic                       rd_ready,
   input  logic                       clear_status,
   output logic                       rd_valid,
   output logic [PWM_REG_WIDTH-1:0]   rd_value,
   output logic [TS_WIDTH-1:0]        rd_timestamp,
   output logic [FIFO_ADDR_WIDTH:0]   fill_level,
   output logic                       overflow,
   output logic [DROP_CNT_WIDTH-1:0]  dropped_cnt
);

   localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH;
   localparam int PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int ENTRY_W = PWM_REG_WIDTH + TS_WIDTH;
   localparam logic [PRE_W-1:0]          PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
   localparam logic [FIFO_ADDR_WIDTH:0]  FULL_LEVEL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

   logic [PRE_W-1:0]           pre_q, pre_d;
   logic [TS_WIDTH-1:0]        ts_q, ts_d;
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_ADDR_WIDTH:0]   level_q, level_d;
   logic                       ovf_q, ovf_d;
   logic [DROP_CNT_WIDTH-1:0]  drop_q, drop_d;
   logic [PWM_REG_WIDTH-1:0]   last_q, last_d;
   logic                       has_q, has_d;

   logic [ENTRY_W-1:0]         mem_q [DEPTH];
   logic [ENTRY_W-1:0]         head;

   logic                       is_dup;
   logic                       push_req;
   logic                       full;
   logic                       pop;
   logic                       push_ok;
   logic                       drop;

   assign is_dup   = (SUPPRESS_DUPLICATES != 0) && has_q && (value == last_q);
   assign push_req = value_changed && !is_dup;
   assign full     = (level_q == FULL_LEVEL);
   assign rd_valid = (level_q != '0);
   assign pop      = rd_valid && rd_ready;
   // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
   assign push_ok  = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_comb begin
      pre_d    = pre_q;
      ts_d     = ts_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      last_d   = last_q;
      has_d    = has_q;

      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         ts_d  = ts_q + 1'b1;
      end else begin
         pre_d = pre_q + 1'b1;
      end

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         last_d   = value;
         has_d    = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push_ok) begin
         level_d = level_q - 1'b1;
      end

      // A drop coinciding with clear_status restarts the count at one.
      if (drop) begin
         ovf_d = 1'b1;
         if (clear_status) begin
            drop_d = DROP_CNT_WIDTH'(1);
         end else if (drop_q != '1) begin
            drop_d = drop_q + 1'b1;
         end
      end else if (clear_status) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q    <= '0;
         ts_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
         last_q   <= '0;
         has_q    <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         ts_q     <= ts_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         last_q   <= last_d;
         has_q    <= has_d;
      end
   end

   // Storage is left unreset; the read port is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {value, ts_q};
      end
   end

   assign head         = mem_q[rd_ptr_q];
   assign rd_value     = rd_valid ? head[ENTRY_W-1:TS_WIDTH] : '0;
   assign rd_timestamp = rd_valid ? head[TS_WIDTH-1:0] : '0;
   assign fill_level   = level_q;
   assign overflow     = ovf_q;
   assign dropped_cnt  = drop_q;

endmodule

// File: tb/tb_contrast_change_logger.sv
// Drives three logger variants (dedup, no dedup, 4-bit timestamp) with shared
// stimulus and checks each against a queue-based reference every cycle.
module tb_contrast_change_logger;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       value_changed = 1'b0;
   logic [9:0] value = '0;
   logic       rd_ready = 1'b0;
   logic       clear_status = 1'b0;

   logic        v0, v1, v2;
   logic [9:0]  val0, val1, val2;
   logic [15:0] ts0, ts1;
   logic [3:0]  ts2;
   logic [3:0]  fl0, fl1, fl2;
   logic        ov0, ov1, ov2;
   logic [7:0]  dc0, dc1, dc2;

   int total = 0;
   int bad = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   contrast_change_logger #(.TICK_CYCLES(4), .SUPPRESS_DUPLICATES(1)) u_dut (
      .clk(clk), .reset(reset), .value_changed(value_changed), .value(value),
      .rd_ready(rd_ready), .clear_status(clear_status), .rd_valid(v0),
      .rd_value(val0), .rd_timestamp(ts0), .fill_level(fl0), .overflow(ov0),
      .dropped_cnt(dc0));

   contrast_change_logger #(.TICK_CYCLES(4), .SUPPRESS_DUPLICATES(0)) u_nodup (
      .clk(clk), .reset(reset), .value_changed(value_changed), .value(value),
      .rd_ready(rd_ready), .clear_status(clear_status), .rd_valid(v1),
      .rd_value(val1), .rd_timestamp(ts1), .fill_level(fl1), .overflow(ov1),
      .dropped_cnt(dc1));

   contrast_change_logger #(.TICK_CYCLES(4), .TS_WIDTH(4)) u_ts4 (
      .clk(clk), .reset(reset), .value_changed(value_changed), .value(value),
      .rd_ready(rd_ready), .clear_status(clear_status), .rd_valid(v2),
      .rd_value(val2), .rd_timestamp(ts2), .fill_level(fl2), .overflow(ov2),
      .dropped_cnt(dc2));

   // Reference: per-instance queue of {value, timestamp}; the timestamp is
   // derived from the number of clock edges seen since reset.
   logic [25:0] mq [3][$];
   int          m_edges;
   int          m_has  [3];
   int          m_last [3];
   int          m_ovf  [3];
   int          m_drop [3];

   function automatic int ts_mask(input int i);
      return (i == 2) ? 15 : 16'hFFFF;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_edges = 0;
         for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_has[i] = 0; m_last[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            int  ts;
            bit  do_pop, req, is_full;
            ts      = (m_edges / 4) & ts_mask(i);
            do_pop  = (mq[i].size() != 0) && rd_ready;
            req     = value_changed && !((i != 1) && m_has[i] != 0 && int'(value) == m_last[i]);
            is_full = (mq[i].size() == 8);
            if (do_pop) void'(mq[i].pop_front());
            if (req && (!is_full || do_pop)) begin
               mq[i].push_back({value, 16'(ts)});
               m_last[i] = int'(value);
               m_has[i] = 1;
            end
            if (req && is_full && !do_pop) begin
               m_ovf[i] = 1;
               m_drop[i] = clear_status ? 1 : ((m_drop[i] == 255) ? 255 : m_drop[i] + 1);
            end else if (clear_status) begin
               m_ovf[i] = 0;
               m_drop[i] = 0;
            end
         end
         m_edges = m_edges + 1;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_inst(input int i, input logic v, input logic [9:0] rv,
                             input logic [15:0] rt, input logic [3:0] fl,
                             input logic ov, input logic [7:0] dc);
      int n;
      n = mq[i].size();
      chk($sformatf("u%0d.rd_valid", i), v, (n != 0));
      chk($sformatf("u%0d.fill_level", i), fl, n);
      chk($sformatf("u%0d.rd_value", i), rv, (n != 0) ? mq[i][0][25:16] : 0);
      chk($sformatf("u%0d.rd_timestamp", i), rt, (n != 0) ? mq[i][0][15:0] : 0);
      chk($sformatf("u%0d.overflow", i), ov, m_ovf[i]);
      chk($sformatf("u%0d.dropped_cnt", i), dc, m_drop[i]);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check_inst(0, v0, val0, ts0, fl0, ov0, dc0);
         check_inst(1, v1, val1, ts1, fl1, ov1, dc1);
         check_inst(2, v2, val2, {12'd0, ts2}, fl2, ov2, dc2);
      end
   end

   task automatic cyc(input logic vc, input int val, input logic rdy, input logic clr);
      value_changed = vc;
      value = 10'(val);
      rd_ready = rdy;
      clear_status = clr;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      value_changed = 1'b0;
      rd_ready = 1'b0;
      clear_status = 1'b0;
   endtask

   task automatic idle_to(input int target);
      while (edge_n < target) cyc(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev [3];
      int et [3];

      // Idle after reset, then confirm the timestamp reached 3.
      do_reset();
      chk("reset.rd_valid", v0, 0);
      chk("reset.rd_value", val0, 0);
      chk("reset.rd_timestamp", ts0, 0);
      idle_to(12);
      chk("idle.rd_valid", v0, 0);
      chk("idle.fill_level", fl0, 0);
      cyc(1'b1, 7, 1'b0, 1'b0);
      chk("idle.ts_after_3_ticks", ts0, 3);
      chk("idle.latency_valid", v0, 1);
      cyc(1'b0, 0, 1'b1, 1'b0);

      // Three strobes at timestamps 2, 5, 9, then drain in order.
      do_reset();
      idle_to(8);  cyc(1'b1, 11, 1'b0, 1'b0);
      idle_to(20); cyc(1'b1, 22, 1'b0, 1'b0);
      idle_to(36); cyc(1'b1, 33, 1'b0, 1'b0);
      ev = '{11, 22, 33};
      et = '{2, 5, 9};
      for (int k = 0; k < 3; k++) begin
         chk("order.fill_level", fl0, 3 - k);
         chk("order.rd_value", val0, ev[k]);
         chk("order.rd_timestamp", ts0, et[k]);
         cyc(1'b0, 0, 1'b1, 1'b0);
      end
      chk("order.empty", fl0, 0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("order.ready_when_empty", fl0, 0);

      // Duplicate suppression vs. no suppression.
      do_reset();
      cyc(1'b1, 44, 1'b0, 1'b0);
      cyc(1'b1, 44, 1'b0, 1'b0);
      cyc(1'b1, 55, 1'b0, 1'b0);
      chk("dedup.fill_level", fl0, 2);
      chk("dedup.overflow", ov0, 0);
      chk("nodup.fill_level", fl1, 3);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("dedup.second", val0, 55);
      chk("nodup.second", val1, 44);

      // Overfill: ten strobes into eight slots.
      do_reset();
      for (int k = 0; k < 10; k++) cyc(1'b1, 100 + k, 1'b0, 1'b0);
      chk("full.fill_level", fl0, 8);
      chk("full.overflow", ov0, 1);
      chk("full.dropped_cnt", dc0, 2);
      chk("full.head", val0, 100);
      cyc(1'b0, 0, 1'b0, 1'b1);
      chk("clear.overflow", ov0, 0);
      chk("clear.dropped_cnt", dc0, 0);
      chk("clear.fill_level", fl0, 8);
      chk("clear.head", val0, 100);

      // Push and pop together while full: no drop.
      cyc(1'b1, 200, 1'b1, 1'b0);
      chk("fullpp.fill_level", fl0, 8);
      chk("fullpp.overflow", ov0, 0);
      chk("fullpp.head", val0, 101);
      // Drop in the same cycle as clear: drop wins.
      cyc(1'b1, 201, 1'b0, 1'b1);
      chk("dropclr.overflow", ov0, 1);
      chk("dropclr.dropped_cnt", dc0, 1);
      // Saturate the drop counter.
      for (int k = 0; k < 260; k++) cyc(1'b1, 300 + (k % 2), 1'b0, 1'b0);
      chk("sat.dropped_cnt", dc0, 255);
      for (int k = 0; k < 7; k++) begin
         chk("drain.order", val0, 101 + k);
         cyc(1'b0, 0, 1'b1, 1'b0);
      end
      chk("drain.last_is_new", val0, 200);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("drain.empty", v0, 0);

      // Timestamp wrap in the 4-bit variant.
      do_reset();
      idle_to(60); cyc(1'b1, 50, 1'b0, 1'b0);
      idle_to(64); cyc(1'b1, 51, 1'b0, 1'b0);
      idle_to(72); cyc(1'b1, 52, 1'b0, 1'b0);
      chk("wrap.wide_ts", ts0, 15);
      et = '{15, 0, 2};
      for (int k = 0; k < 3; k++) begin
         chk("wrap.ts4", ts2, et[k]);
         cyc(1'b0, 0, 1'b1, 1'b0);
      end

      // Reset with five entries queued.
      for (int k = 0; k < 5; k++) cyc(1'b1, 60 + k, 1'b0, 1'b0);
      chk("midrst.before", fl0, 5);
      reset = 1'b1;
      #1;
      chk("midrst.rd_valid", v0, 0);
      chk("midrst.fill_level", fl0, 0);
      @(posedge clk);
      #1;
      chk("midrst.next_valid", v0, 0);
      chk("midrst.next_fill", fl0, 0);
      @(negedge clk);
      reset = 1'b0;
      edge_n = 0;
      repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/contrast_change_logger.md
Name: contrast_change_logger

Overview:
- Downstream consumer of the contrast box PWM controller.
- Captures each PWM on-time update, indicated by a single-cycle changed strobe, together with a free-running timestamp.
- Buffers the captured events in a first-word-fall-through FIFO.
- The SpartanMC peripheral bridge drains the FIFO through a valid/ready read port, so the logging firmware gets every contrast change in order, with time and loss accounting.

Parameters:
- PWM_REG_WIDTH, 10, width of the logged PWM on-time value.
- TS_WIDTH, 16, width of the timestamp counter.
- TICK_CYCLES, 16000, clk cycles per timestamp tick (1 ms at 16 MHz); must be >= 1.
- FIFO_ADDR_WIDTH, 3, FIFO depth = 2^FIFO_ADDR_WIDTH entries (default 8).
- SUPPRESS_DUPLICATES, 1, when 1, a strobe carrying the same value as the last accepted entry is ignored.
- DROP_CNT_WIDTH, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- value_changed  input  1  single-cycle strobe from the PWM controller; value is valid in the same cycle.
- value  input  PWM_REG_WIDTH  current PWM on-time.
- rd_ready  input  1  consumer accepts the head entry this cycle.
- clear_status  input  1  clears overflow and dropped_cnt.
- rd_valid  output  1  FIFO not empty.
- rd_value  output  PWM_REG_WIDTH  head entry value.
- rd_timestamp  output  TS_WIDTH  head entry timestamp.
- fill_level  output  FIFO_ADDR_WIDTH+1  number of stored entries.
- overflow  output  1  sticky flag: at least one event was dropped.
- dropped_cnt  output  DROP_CNT_WIDTH  saturating count of dropped events.

Behaviour:
- Reset (asynchronous, active-high):
  - Prescaler, timestamp, FIFO pointers, fill_level, overflow, dropped_cnt and the last-accepted-value register go to 0.
  - The last-accepted "has value" flag clears.
  - rd_valid=0; rd_value and rd_timestamp read 0.
  - Reset mid-transfer discards all stored entries.
- Timestamp:
  - The prescaler counts 0..TICK_CYCLES-1.
  - On the cycle the prescaler equals TICK_CYCLES-1 it returns to 0 and the timestamp increments.
  - The timestamp wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Capture:
  - A push is requested when value_changed=1.
  - If SUPPRESS_DUPLICATES=1, the "has value" flag is set and value equals the last accepted value, the request is ignored: no push, no drop count.
  - A push stores {value, timestamp as registered at that edge, pre-increment}.
  - An accepted push updates the last-accepted value and sets "has value".
- FIFO:
  - First-word-fall-through: rd_valid = (fill_level != 0), and rd_value/rd_timestamp show the head entry combinationally from storage.
  - A pop occurs when rd_valid && rd_ready. rd_ready while empty has no effect.
  - A push or pop becomes visible on the next cycle. Write-to-rd_valid latency is 1 cycle.
  - Simultaneous push and pop when not empty: both happen, fill_level unchanged.
  - Simultaneous push and pop when full: both happen (the pop frees the slot), no drop.
  - Push when full without a pop: entry dropped. overflow is set, and dropped_cnt increments, saturating at 2^DROP_CNT_WIDTH-1.
  - Push when empty with rd_ready=1: no bypass. The entry appears next cycle.
  - Pointers wrap modulo the depth. fill_level ranges 0..2^FIFO_ADDR_WIDTH.
- Status:
  - clear_status clears overflow and dropped_cnt.
  - If a drop occurs in the same cycle as clear_status, the drop wins: overflow=1, dropped_cnt=1.
- No combinational path from rd_ready to rd_valid.

Test Plan:
- Reset then idle for 3*TICK_CYCLES (TICK_CYCLES=4 in bench) -> rd_valid=0, fill_level=0, timestamp advanced by 3, no entries.
- Strobes with value 11, 22, 33 at timestamps 2, 5, 9, with rd_ready=0, then rd_ready=1 -> three entries popped in order (11,2), (22,5), (33,9); fill_level steps 3,2,1,0.
- SUPPRESS_DUPLICATES=1: strobes 44, 44, 55 -> two entries (44, 55), overflow=0; repeat with SUPPRESS_DUPLICATES=0 -> three entries.
- Ten distinct strobes into an 8-deep FIFO, no reads -> fill_level=8, overflow=1, dropped_cnt=2, first entry unchanged. clear_status -> overflow=0, dropped_cnt=0, data kept.
- FIFO full with strobe and rd_ready=1 in the same cycle -> no drop, fill_level stays 8, new value is last in order.
- TS_WIDTH=4: run past 15 ticks, then strobe -> timestamp wraps to 0..n correctly. Assert reset while 5 entries are queued -> next cycle rd_valid=0, fill_level=0.
